// File: rtl/instr_dispatcher.sv
// ---------------------------------------------------------------------------
// instr_dispatcher
//
// Sits upstream of the 8-bit processor core (regA/regB -> ULA -> regC).
//
// Operation:
//   - Instructions {opcode, operand1, operand2} are buffered in a DEPTH-entry FIFO.
//   - One instruction is issued to the core at a time and held stable for the
//     core's LATENCY.
//   - The core's result and flags are then captured.
//   - The captured pair is offered on a valid/ready output channel together
//     with a wrapping completion number.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid / in_ready                 instruction input handshake
//   in_opcode, in_op1, in_op2           instruction fields
//   proc_opcode/operand1/operand2       registered drive to the core
//   proc_result, proc_flags             core result (regC) and flags (ULA)
//   out_valid / out_ready               result output handshake
//   out_result, out_flags, out_seq      captured result, flags, completion number
//   fifo_count                          number of stored (not yet issued) entries
//   busy                                high whenever an instruction is in flight
// ---------------------------------------------------------------------------
module instr_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_opcode,
    input  logic [7:0]               in_op1,
    input  logic [7:0]               in_op2,
    output logic [7:0]               proc_opcode,
    output logic [7:0]               proc_operand1,
    output logic [7:0]               proc_operand2,
    input  logic [7:0]               proc_result,
    input  logic [7:0]               proc_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_result,
    output logic [7:0]               out_flags,
    output logic [7:0]               out_seq,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [AW:0]     FULL_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     ONE_C   = (AW + 1)'(1);
    localparam logic [AW-1:0]   PSTEP_C = AW'(1);
    localparam logic [CNTW-1:0] LAT_C   = CNTW'(LATENCY);
    localparam logic [CNTW-1:0] WSTEP_C = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic [CNTW-1:0] wait_q;
    logic [23:0]     mem_q [DEPTH];
    logic [23:0]     head;

    logic [7:0]      proc_opcode_q;
    logic [7:0]      proc_operand1_q;
    logic [7:0]      proc_operand2_q;
    logic            out_valid_q;
    logic [7:0]      out_result_q;
    logic [7:0]      out_flags_q;
    logic [7:0]      out_seq_q;

    logic            push;
    logic            pop;

    // Ready is a pure function of occupancy: a full FIFO refuses even when a
    // pop happens on the same edge, so no combinational path from the FSM.
    assign in_ready = (count_q < FULL_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_opcode, in_op1, in_op2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            wait_q          <= '0;
            proc_opcode_q   <= '0;
            proc_operand1_q <= '0;
            proc_operand2_q <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_flags_q     <= '0;
            out_seq_q       <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PSTEP_C;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PSTEP_C;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {proc_opcode_q, proc_operand1_q, proc_operand2_q} <= head;
                        wait_q  <= '0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands are held; the core needs LATENCY edges to
                    // load regA/regB and then regC before the result is valid.
                    if (wait_q == LAT_C) begin
                        out_result_q <= proc_result;
                        out_flags_q  <= proc_flags;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        wait_q <= wait_q + WSTEP_C;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_seq_q   <= out_seq_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign proc_opcode   = proc_opcode_q;
    assign proc_operand1 = proc_operand1_q;
    assign proc_operand2 = proc_operand2_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_flags     = out_flags_q;
    assign out_seq       = out_seq_q;
    assign fifo_count    = count_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_instr_dispatcher.sv
// ---------------------------------------------------------------------------
// Testbench for instr_dispatcher.
//
// Setup:
//   - A small core model (regA/regB load, then regC load) computes
//     result = op1 + op2; flags = {carry, zero} in the low two bits.
//   - Accepted instructions push their expected result/flags into a queue.
//   - A monitor pops the queue on each output handshake and compares
//     result, flags and the expected completion number.
//
// Test sequence:
//   - Directed checks cover reset state, the single-instruction latency,
//     FIFO full behaviour, backpressure stability, sequence-number wrap,
//     simultaneous push/pop and abort on reset.
//   - A randomized traffic phase closes the run.
// ---------------------------------------------------------------------------
module tb_instr_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_opcode = '0, in_op1 = '0, in_op2 = '0;
    logic [7:0] proc_opcode, proc_operand1, proc_operand2;
    logic [7:0] proc_result, proc_flags;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result, out_flags, out_seq;
    logic [2:0] fifo_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_dispatcher #(.DEPTH(4), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
        .proc_opcode(proc_opcode), .proc_operand1(proc_operand1),
        .proc_operand2(proc_operand2),
        .proc_result(proc_result), .proc_flags(proc_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_seq(out_seq),
        .fifo_count(fifo_count), .busy(busy)
    );

    // Core model: operands register into regA/regB, sum registers into regC.
    logic [7:0] reg_a = '0, reg_b = '0, reg_c = '0;
    logic [8:0] ula_sum;
    always @(posedge clk) begin
        reg_a <= proc_operand1;
        reg_b <= proc_operand2;
        reg_c <= reg_a + reg_b;
    end
    assign ula_sum     = {1'b0, reg_a} + {1'b0, reg_b};
    assign proc_result = reg_c;
    assign proc_flags  = {6'b0, ula_sum[8], (ula_sum[7:0] == 8'd0)};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: {result, flags} of every accepted instruction, in order.
    logic [15:0] exp_q [$];
    logic [7:0]  seq_m = 8'd0;
    int          n_done = 0;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            seq_m = 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    chk("result_tuple", {out_result, out_flags, out_seq},
                        {exp_q[0], seq_m});
                    void'(exp_q.pop_front());
                end
                seq_m = seq_m + 8'd1;
                n_done++;
            end
            if (in_valid && in_ready) begin
                logic [8:0] s;
                s = {1'b0, in_op1} + {1'b0, in_op2};
                exp_q.push_back({s[7:0], 6'b0, s[8], (s[7:0] == 8'd0)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((busy || fifo_count != 0 || out_valid) && budget < 500) begin
            tick();
            budget++;
        end
        chk("drain_timeout", (budget < 500), 1);
    endtask

    initial begin
        int acc;
        int budget;
        logic [63:0] snap;

        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {out_result, out_flags, out_seq}, 0);
        chk("rst_proc", {proc_opcode, proc_operand1, proc_operand2}, 0);

        // Single instruction latency
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 8'h01; in_op1 = 8'h05; in_op2 = 8'h03;
        tick();                                    // E0
        in_valid = 1'b0;
        tick(); tick(); tick();                    // E0+3
        chk("single_valid_early", out_valid, 0);
        tick();                                    // E0+4
        chk("single_valid", out_valid, 1);
        chk("single_result", out_result, 8'h08);
        chk("single_flag0", out_flags[0], 0);
        chk("single_seq", out_seq, 8'h00);
        chk("single_opcode", proc_opcode, 8'h01);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_release", out_valid, 0);

        // Full FIFO and simultaneous push/pop
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_opcode = 8'($urandom);
            in_op1 = 8'($urandom);
            in_op2 = 8'($urandom);
            if (i == 5) begin
                chk("full_in_ready", in_ready, 0);
                chk("full_count", fifo_count, 4);
            end
            acc += int'(in_ready);
            tick();
            if (i == 1) chk("simul_count", fifo_count, 1);
        end
        in_valid = 1'b0;
        chk("full_accepted", acc, 5);

        // Backpressure: everything stays put while held in DONE
        budget = 0;
        while (!out_valid && budget < 20) begin
            tick();
            budget++;
        end
        chk("bp_reach_done", out_valid, 1);
        snap = {16'h0, out_result, out_flags, out_seq,
                proc_opcode, proc_operand1, proc_operand2};
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_stable", {16'h0, out_result, out_flags, out_seq,
                proc_opcode, proc_operand1, proc_operand2}, snap);
        end
        chk("bp_still_valid", out_valid, 1);
        drain();
        out_ready = 1'b0;

        // Sequence wrap: 257 instructions FF+01
        do_reset();
        out_ready = 1'b1;
        acc = 0;
        budget = 0;
        while (acc < 257 && budget < 3000) begin
            in_valid = 1'b1;
            in_opcode = 8'($urandom);
            in_op1 = 8'hFF;
            in_op2 = 8'h01;
            acc += int'(in_ready);
            tick();
            budget++;
        end
        chk("wrap_accepted", acc, 257);
        n_done = 0;
        drain();
        chk("wrap_final_seq", out_seq, 8'h01);
        chk("wrap_final_result", {out_result, out_flags}, 16'h0003);

        // Abort: reset in the second EXEC cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_opcode = 8'hA5; in_op1 = 8'h11; in_op2 = 8'h22;
        tick();                                    // E0 accept
        in_valid = 1'b0;
        tick();                                    // E1 pop, 1st EXEC cycle
        tick();                                    // 2nd EXEC cycle
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_fifo_count", fifo_count, 0);
        chk("abort_busy", busy, 0);
        in_valid = 1'b1; in_opcode = 8'h3C; in_op1 = 8'h40; in_op2 = 8'h02;
        tick();
        in_valid = 1'b0;
        budget = 0;
        while (!out_valid && budget < 20) begin
            tick();
            budget++;
        end
        chk("abort_next_valid", out_valid, 1);
        chk("abort_next_seq", out_seq, 8'h00);
        chk("abort_next_result", out_result, 8'h42);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_opcode = 8'($urandom);
            in_op1    = 8'($urandom);
            in_op2    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            chk("count_bound", (fifo_count <= 4), 1);
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
